// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: CPU, loader and BRAM Port B signal bundle for the port arbiter.
interface bram_port_arbiter_if #(parameter int ADDR_W = 11);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_wdata, cpu_rdata;
  logic              ldr_req, ldr_we, ldr_done, ldr_gnt, ldr_rvalid;
  logic [ADDR_W-1:0] ldr_addr;
  logic [3:0]        ldr_be;
  logic [31:0]       ldr_wdata, ldr_rdata;
  logic              boot_active, mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din, mem_dout;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_be, ldr_wdata, ldr_done, mem_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
    output boot_active, mem_en, mem_we, mem_addr, mem_din
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_be, ldr_wdata, ldr_done, mem_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
    input  boot_active, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares BRAM Port B between CPU and boot loader; loader-only in BOOT,
// CPU-priority with a starvation cap in RUN, read data steered back after 1-cycle latency.
module bram_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int STARVE_MAX = 8
) (
  input logic                clk,
  input logic                rst,
  bram_port_arbiter_if.slave bus
);
  typedef enum logic {BOOT, RUN} state_t;
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);
  state_t            state_q, state_d;
  logic [7:0]        starve_q, starve_d;
  logic              cpu_rv_q, cpu_rv_d, ldr_rv_q, ldr_rv_d;
  logic              boot, starve_hit, cpu_gnt, ldr_gnt;
  logic [ADDR_W-1:0] addr_sel;
  always_comb begin
    boot       = state_q == BOOT;
    starve_hit = starve_q == SMAX;
    cpu_gnt    = !rst && !boot && bus.cpu_req && !(bus.ldr_req && starve_hit);
    ldr_gnt    = !rst && bus.ldr_req && (boot || !bus.cpu_req || starve_hit);
    addr_sel   = ldr_gnt ? bus.ldr_addr : bus.cpu_addr;
    state_d    = boot && bus.ldr_done ? RUN : state_q;
    // Counts only CPU wins over a waiting loader; any loader grant or idle loader resets it.
    starve_d   = (boot || ldr_gnt || !bus.ldr_req) ? 8'd0 :
                 (cpu_gnt && !starve_hit) ? starve_q + 8'd1 : starve_q;
    cpu_rv_d   = cpu_gnt && !bus.cpu_we;
    ldr_rv_d   = ldr_gnt && !bus.ldr_we;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      starve_q <= 8'd0;
      cpu_rv_q <= 1'b0;
      ldr_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cpu_rv_q <= cpu_rv_d;
      ldr_rv_q <= ldr_rv_d;
    end
  end
  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.ldr_gnt     = ldr_gnt;
  assign bus.boot_active = boot;
  assign bus.mem_en      = cpu_gnt || ldr_gnt;
  assign bus.mem_we      = ldr_gnt ? (bus.ldr_we ? bus.ldr_be : 4'h0) :
                           (cpu_gnt && bus.cpu_we) ? bus.cpu_be : 4'h0;
  assign bus.mem_addr    = addr_sel;
  assign bus.mem_din     = ldr_gnt ? bus.ldr_wdata : bus.cpu_wdata;
  assign bus.cpu_rvalid  = cpu_rv_q;
  assign bus.ldr_rvalid  = ldr_rv_q;
  assign bus.cpu_rdata   = cpu_rv_q ? bus.mem_dout : 32'h0;
  assign bus.ldr_rdata   = ldr_rv_q ? bus.mem_dout : 32'h0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: table-driven checks of grants, mem muxing and read return, plus starvation and reset sequences.
module tb_bram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  logic [31:0] ram [0:2047];
  bram_port_arbiter_if #(.ADDR_W(11)) bus ();
  bram_port_arbiter #(.ADDR_W(11), .STARVE_MAX(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
      if (bus.mem_we == 4'h0) bus.mem_dout <= ram[bus.mem_addr];
    end
  typedef struct packed {
    logic c_req, c_we; logic [10:0] c_addr; logic [3:0] c_be; logic [31:0] c_wd;
    logic l_req, l_we; logic [10:0] l_addr; logic [3:0] l_be; logic [31:0] l_wd; logic l_done;
    logic e_cg, e_lg, e_en; logic [3:0] e_we; logic [10:0] e_addr; logic [31:0] e_din;
    logic e_boot, e_crv; logic [31:0] e_crd; logic e_lrv; logic [31:0] e_lrd;
  } vec_t;
  vec_t v [19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t x);
    bus.cpu_req = x.c_req; bus.cpu_we = x.c_we; bus.cpu_addr = x.c_addr;
    bus.cpu_be = x.c_be; bus.cpu_wdata = x.c_wd;
    bus.ldr_req = x.l_req; bus.ldr_we = x.l_we; bus.ldr_addr = x.l_addr;
    bus.ldr_be = x.l_be; bus.ldr_wdata = x.l_wd; bus.ldr_done = x.l_done;
  endtask
  initial begin
    vec_t idle;
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    ram[11'h020] = 32'hA5A5_0020;
    ram[11'h010] = 32'h1010_1010;
    ram[11'h011] = 32'h1111_1111;
    ram[11'h012] = 32'h1212_1212;
    bus.mem_dout = 32'h0;
    idle = '0;
    for (int i = 0; i < 5; i++)
      v[i] = '{1'b1,1'b0,11'h020,4'h0,32'h0, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b0,
               1'b0,1'b0,1'b0,4'h0,11'h020,32'h0,1'b1,1'b0,32'h0,1'b0,32'h0};
    v[5]  = '{1'b1,1'b0,11'h020,4'h0,32'h0, 1'b1,1'b1,11'h005,4'hF,32'hDEADBEEF,1'b0,
              1'b0,1'b1,1'b1,4'hF,11'h005,32'hDEADBEEF,1'b1,1'b0,32'h0,1'b0,32'h0};
    v[6]  = '{1'b1,1'b0,11'h020,4'h0,32'h0, 1'b1,1'b0,11'h005,4'h0,32'h0,1'b0,
              1'b0,1'b1,1'b1,4'h0,11'h005,32'h0,1'b1,1'b0,32'h0,1'b0,32'h0};
    v[7]  = '{1'b1,1'b0,11'h020,4'h0,32'h0, 1'b1,1'b1,11'h006,4'h3,32'h12345678,1'b1,
              1'b0,1'b1,1'b1,4'h3,11'h006,32'h12345678,1'b1,1'b0,32'h0,1'b1,32'hDEADBEEF};
    v[8]  = '{1'b1,1'b0,11'h020,4'h0,32'h0, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b0,
              1'b1,1'b0,1'b1,4'h0,11'h020,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0};
    v[9]  = '{1'b1,1'b0,11'h010,4'h0,32'h0, 1'b1,1'b0,11'h011,4'h0,32'h0,1'b0,
              1'b1,1'b0,1'b1,4'h0,11'h010,32'h0,1'b0,1'b1,32'hA5A50020,1'b0,32'h0};
    v[10] = '{1'b0,1'b0,11'h010,4'h0,32'h0, 1'b1,1'b0,11'h011,4'h0,32'h0,1'b0,
              1'b0,1'b1,1'b1,4'h0,11'h011,32'h0,1'b0,1'b1,32'h10101010,1'b0,32'h0};
    v[11] = '{1'b1,1'b0,11'h012,4'h0,32'h0, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b0,
              1'b1,1'b0,1'b1,4'h0,11'h012,32'h0,1'b0,1'b0,32'h0,1'b1,32'h11111111};
    v[12] = '{1'b0,1'b0,11'h012,4'h0,32'h0, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b0,
              1'b0,1'b0,1'b0,4'h0,11'h012,32'h0,1'b0,1'b1,32'h12121212,1'b0,32'h0};
    v[13] = '{1'b0,1'b0,11'h012,4'h0,32'h0, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b1,
              1'b0,1'b0,1'b0,4'h0,11'h012,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0};
    v[14] = '{1'b0,1'b0,11'h012,4'h0,32'h0, 1'b1,1'b0,11'h006,4'h0,32'h0,1'b0,
              1'b0,1'b1,1'b1,4'h0,11'h006,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0};
    v[15] = '{1'b0,1'b0,11'h012,4'h0,32'h0, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b0,
              1'b0,1'b0,1'b0,4'h0,11'h012,32'h0,1'b0,1'b0,32'h0,1'b1,32'h00005678};
    v[16] = '{1'b1,1'b1,11'h020,4'hC,32'hCAFE0000, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b0,
              1'b1,1'b0,1'b1,4'hC,11'h020,32'hCAFE0000,1'b0,1'b0,32'h0,1'b0,32'h0};
    v[17] = '{1'b1,1'b0,11'h020,4'h0,32'h0, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b0,
              1'b1,1'b0,1'b1,4'h0,11'h020,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0};
    v[18] = '{1'b0,1'b0,11'h020,4'h0,32'h0, 1'b0,1'b0,11'h000,4'h0,32'h0,1'b0,
              1'b0,1'b0,1'b0,4'h0,11'h020,32'h0,1'b0,1'b1,32'hCAFE0020,1'b0,32'h0};
    // Reset: grants suppressed even with both requests high.
    drive(idle);
    bus.cpu_req = 1'b1; bus.ldr_req = 1'b1;
    tick(); tick();
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    chk("rst_ldr_gnt", 32'(bus.ldr_gnt), 32'h0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_boot", 32'(bus.boot_active), 32'h1);
    chk("rst_rvalid", {30'h0, bus.cpu_rvalid, bus.ldr_rvalid}, 32'h0);
    drive(idle);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      drive(v[i]);
      #1;
      chk($sformatf("v%0d_cpu_gnt", i), 32'(bus.cpu_gnt), 32'(v[i].e_cg));
      chk($sformatf("v%0d_ldr_gnt", i), 32'(bus.ldr_gnt), 32'(v[i].e_lg));
      chk($sformatf("v%0d_mem_en", i), 32'(bus.mem_en), 32'(v[i].e_en));
      chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(v[i].e_we));
      chk($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(v[i].e_addr));
      chk($sformatf("v%0d_mem_din", i), bus.mem_din, v[i].e_din);
      chk($sformatf("v%0d_boot", i), 32'(bus.boot_active), 32'(v[i].e_boot));
      chk($sformatf("v%0d_cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(v[i].e_crv));
      chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, v[i].e_crd);
      chk($sformatf("v%0d_ldr_rvalid", i), 32'(bus.ldr_rvalid), 32'(v[i].e_lrv));
      chk($sformatf("v%0d_ldr_rdata", i), bus.ldr_rdata, v[i].e_lrd);
    end
    // Both requesters held: 8 CPU grants then one forced loader grant, repeating.
    for (int i = 0; i < 18; i++) begin
      tick();
      drive(idle);
      bus.cpu_req = 1'b1; bus.cpu_addr = 11'h030;
      bus.ldr_req = 1'b1; bus.ldr_addr = 11'h031;
      #1;
      chk($sformatf("starve%0d_cpu_gnt", i), 32'(bus.cpu_gnt), 32'(i % 9 != 8));
      chk($sformatf("starve%0d_ldr_gnt", i), 32'(bus.ldr_gnt), 32'(i % 9 == 8));
    end
    // CPU read granted, then reset drops the pending return and re-enters BOOT.
    tick();
    drive(idle);
    bus.cpu_req = 1'b1; bus.cpu_addr = 11'h020;
    #1;
    chk("rr_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    rst = 1'b1;
    bus.ldr_req = 1'b1;
    #1;
    chk("rr_rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    chk("rr_rst_ldr_gnt", 32'(bus.ldr_gnt), 32'h0);
    chk("rr_rst_mem_en", 32'(bus.mem_en), 32'h0);
    tick();
    chk("rr_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("rr_boot", 32'(bus.boot_active), 32'h1);
    rst = 1'b0;
    bus.ldr_req = 1'b0;
    tick();
    chk("rr_boot_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    chk("rr_boot_active", 32'(bus.boot_active), 32'h1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the data port (Port B) of the 8 KB program/data BRAM between two requesters: the CPU load/store path and the UART boot loader.
- After reset the loader has exclusive access to fill the BRAM with the program image. After the loader signals completion, the CPU has priority, with a starvation cap so late loader/debug traffic still progresses.
- Sits between the byte-lane/MMIO logic and the BRAM IP. Tracks the BRAM's 1-cycle read latency so read data is steered back to the requester that issued the read.

Parameters:
- ADDR_W, 11, word-address width (2048 words).
- STARVE_MAX, 8, max consecutive CPU grants while loader waits before the loader is forced a grant (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_be  in  4  CPU byte enables (writes only)
- cpu_wdata  in  32  CPU write data, already lane-aligned
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  32  CPU read data
- ldr_req  in  1  loader request
- ldr_we  in  1  loader write/read
- ldr_addr  in  ADDR_W  loader word address
- ldr_be  in  4  loader byte enables
- ldr_wdata  in  32  loader write data
- ldr_done  in  1  one-cycle pulse: image load complete
- ldr_gnt  out  1  loader access accepted
- ldr_rvalid  out  1  loader read data valid
- ldr_rdata  out  32  loader read data
- boot_active  out  1  high while in BOOT (holds CPU in reset externally)
- mem_en  out  1  BRAM Port B enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_W  BRAM word address
- mem_din  out  32  BRAM write data
- mem_dout  in  32  BRAM read data (valid 1 cycle after enabled read)

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst. While rst is high, both gnt outputs are forced to 0.
- Reset values:
  - state=BOOT, boot_active=1.
  - starve_cnt=0.
  - cpu_rvalid=0, ldr_rvalid=0.
  - Read-owner register cleared.
  - gnt outputs 0 and mem_en=0 during rst.
- FSM states:
  - BOOT: ldr_gnt=ldr_req; cpu_gnt=0 regardless of cpu_req. ldr_done sampled high moves to RUN next cycle. A loader access granted in the same cycle as ldr_done completes normally.
  - RUN: boot_active=0. No return to BOOT except via rst.
- RUN grant rules (combinational from req and registered state):
  - Only cpu_req: CPU granted.
  - Only ldr_req: loader granted.
  - Both: CPU granted unless starve_cnt==STARVE_MAX, in which case the loader is granted.
- starve_cnt (RUN only):
  - Increments (saturating at STARVE_MAX) when the CPU is granted while ldr_req=1.
  - Clears when the loader is granted or ldr_req=0.
- Exactly one gnt at most per cycle. The granted requester's signals drive the mem_* outputs:
  - mem_en = cpu_gnt|ldr_gnt.
  - mem_we = granted be when granted we=1, else 4'b0000.
  - mem_addr and mem_din come from the granted requester.
  - With no grant, mem_addr/mem_din hold the CPU values and mem_en=0.
- Read return:
  - A granted read (we=0) registers an owner flag.
  - Next cycle, the owner's rvalid=1 for exactly one cycle, and its rdata = mem_dout.
  - The non-owner's rdata is 0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating requesters each return in order, 1-cycle latency, with no bubble.
- Requesters must hold req and payload stable until gnt. The arbiter never stores payload.
- rst asserted while a read is outstanding: rvalid is 0 in the following cycle and the read is dropped.
- ldr_done in RUN: ignored.

Test Plan:
- Reset, then cpu_req=1 with ldr idle for 5 cycles -> cpu_gnt=0, mem_en=0, boot_active=1. Loader writes addr 0x005 be=4'hF data 0xDEADBEEF -> mem_we=4'hF, mem_addr=0x005 in the ldr_gnt cycle.
- Loader read addr 0x005 in BOOT -> ldr_rvalid=1 next cycle with ldr_rdata=0xDEADBEEF, cpu_rvalid=0.
- ldr_done pulse while ldr write is granted -> write completes. Next cycle boot_active=0, and a pending cpu_req is granted that cycle.
- RUN, cpu_req and ldr_req both held high continuously, STARVE_MAX=8 -> 8 CPU grants, then 1 loader grant, then the pattern repeats (starve_cnt returns 0 after the loader grant).
- Alternating granted reads CPU@0x010 / loader@0x011 / CPU@0x012 -> rvalid pulses alternate one cycle after each grant, each carrying the matching mem_dout.
- CPU read granted, rst asserted the next cycle -> cpu_rvalid=0, state=BOOT, boot_active=1 after that edge.
